program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// big-endian 32-bit words into instruction memory while holding the CPU halted.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [31:0] word_sr;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic        clear;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; a byte is only consumed when rx_ready was presented.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    xfer       = rx_valid && rx_ready;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_LEN_HI;
          clear      = 1'b1;
        end
      end
      S_LEN_HI: if (xfer) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({len[15:8], rx_data} == 16'd0)                 state_next = S_CSUM;
          else if (32'({len[15:8], rx_data}) > MAX_WORDS)    state_next = S_ERROR;
          else                                               state_next = S_DATA;
        end
      end
      S_DATA: if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (32'(words_loaded) + 32'd1 == 32'(len)) state_next = S_CSUM;
        else                                       state_next = S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered status outputs, the latter decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready     <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      word_sr      <= '0;
      csum         <= '0;
      byte_idx     <= '0;
    end else begin
      rx_ready  <= (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                   (state_next == S_DATA)   || (state_next == S_CSUM);
      mem_wr_en <= (state_next == S_WRITE);
      cpu_hold  <= (state_next != S_DONE);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERROR);

      if (clear) begin
        words_loaded <= '0;
        byte_idx     <= '0;
        csum         <= '0;
        len          <= '0;
        word_sr      <= '0;
      end

      if (state == S_LEN_HI && xfer) len[15:8] <= rx_data;
      if (state == S_LEN_LO && xfer) len[7:0]  <= rx_data;

      if (state == S_DATA && xfer) begin
        word_sr  <= {word_sr[23:0], rx_data};
        csum     <= csum ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          mem_wr_addr <= words_loaded[ADDR_WIDTH-1:0];
          mem_wr_data <= {word_sr[23:0], rx_data};
        end
      end

      if (state == S_WRITE) words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random loads checked
// against a stream-level model of the expected writes and final status.
module tb_program_loader;

  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [41:0] wr_q[$];
  logic [31:0] words[$];
  bit          prev_en = 1'b0;
  bit          noise = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe; it must be one cycle wide with rx_ready low.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && mem_wr_en === 1'b1) begin
      wr_q.push_back({mem_wr_addr, mem_wr_data});
      check_eq("wr_rx_ready_low", 64'(rx_ready), 64'd0);
      check_eq("wr_one_cycle", 64'(prev_en), 64'd0);
    end
    prev_en = (mem_wr_en === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit rdy;
    bit got;
    if (gap) begin
      rx_valid = 1'b0;
      start = noise ? 1'b1 : 1'b0;
      @(negedge clock);
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      rdy = rx_ready;
      @(posedge clock);
      got = rdy;
      @(negedge clock);
    end
    rx_valid = 1'b0;
    if (!got) check_eq("rx_timeout", 64'd0, 64'd1);
  endtask

  // Model: words are written in order at addresses 0..N-1; checksum is the XOR of
  // all data bytes; N beyond the memory size aborts right after the length.
  task automatic do_load(input int n, input bit bad, input bit gaps);
    logic [7:0] cs;
    logic [7:0] csb;
    bit         ovf;
    bit         exp_done;
    bit         fin;
    int         exp_words;
    cs  = 8'h00;
    ovf = (n > (1 << AW));
    wr_q.delete();
    foreach (words[i]) cs = cs ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    csb = bad ? (cs ^ 8'($urandom_range(1, 255))) : cs;

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    if (!ovf) begin
      foreach (words[i])
        for (int j = 3; j >= 0; j--) send_byte(words[i][8*j +: 8], gaps);
      send_byte(csb, gaps);
    end

    fin = 1'b0;
    for (int k = 0; k < 20 && !fin; k++) begin
      if (done || error) fin = 1'b1;
      else @(negedge clock);
    end
    if (!fin) check_eq("finish_timeout", 64'd0, 64'd1);

    exp_done  = !ovf && !bad;
    exp_words = ovf ? 0 : n;
    check_eq("done", 64'(done), 64'(exp_done));
    check_eq("error", 64'(error), 64'(!exp_done));
    check_eq("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
    check_eq("words_loaded", 64'(words_loaded), 64'(exp_words));
    check_eq("rx_ready_final", 64'(rx_ready), 64'd0);
    check_eq("write_count", 64'(wr_q.size()), 64'(exp_words));
    for (int i = 0; i < wr_q.size() && i < exp_words; i++) begin
      check_eq("wr_addr", 64'(wr_q[i][41:32]), 64'(i));
      check_eq("wr_data", 64'(wr_q[i][31:0]), 64'(words[i]));
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_rx_ready", 64'(rx_ready), 64'd0);
    check_eq("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    check_eq("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
    check_eq("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
    check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  initial begin
    reset_n  = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Two-word directed load, then bad checksum followed by recovery.
    words = '{32'h11223344, 32'h55667788};
    do_load(2, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b0);
    do_load(2, 1'b0, 1'b0);

    // Length overflow aborts before any write.
    words.delete();
    do_load(1025, 1'b0, 1'b0);
    do_load(65535, 1'b0, 1'b1);

    // Empty loads: checksum must be 00.
    do_load(0, 1'b0, 1'b0);
    do_load(0, 1'b1, 1'b0);

    // Single word with gaps and start noise while loading.
    words = '{32'hdeadbeef};
    noise = 1'b1;
    do_load(1, 1'b0, 1'b1);
    noise = 1'b0;

    // Random loads.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 40);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      noise = 1'($urandom_range(0, 1));
      do_load(n, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      noise = 1'b0;
    end

    // Full memory load.
    words.delete();
    for (int i = 0; i < (1 << AW); i++) words.push_back($urandom);
    do_load(1 << AW, 1'b0, 1'b0);

    // Reset after two data bytes: no write, reset values immediately.
    wr_q.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    reset_n = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rx_data  = 8'hcc;
    rx_valid = 1'b1;
    repeat (6) @(negedge clock);
    rx_valid = 1'b0;
    check_eq("post_reset_writes", 64'(wr_q.size()), 64'd0);
    check_eq("post_reset_rx_ready", 64'(rx_ready), 64'd0);
    check_eq("post_reset_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("post_reset_words", 64'(words_loaded), 64'd0);

    words = '{32'h01020304, 32'hcafef00d, 32'h0badc0de};
    do_load(3, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
